// File: rtl/main_memory_controller.sv
// Word-organised main memory behind the cache controller: fixed-latency
// block refills and write-backs, one-cycle MReady completion pulse.
module main_memory_controller #(
    parameter int ADDR_BITS = 14,
    parameter int LATENCY   = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        MStrobe,
    input  logic        MRW,
    input  logic [31:0] MAddress,
    input  logic [31:0] MDataW,
    output logic [31:0] MDataR,
    output logic        MReady,
    output logic        MBusy,
    output logic [15:0] RdCount,
    output logic [15:0] WrCount
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam int          DEPTH = 2 ** ADDR_BITS;
    localparam logic [7:0]  LOAD  = 8'(LATENCY - 1);

    state_t                 state;
    state_t                 state_nxt;
    logic [7:0]             cnt;
    logic                   strobe_q;
    logic                   rw_q;
    logic [ADDR_BITS-1:0]   idx_q;
    logic [31:0]            data_q;
    logic [31:0]            mem [DEPTH];
    logic                   accept;
    logic                   finish;
    logic                   unused_addr;

    // Byte offset and high address bits alias onto the word index.
    assign unused_addr = ^{MAddress[31:ADDR_BITS+2], MAddress[1:0]};

    assign accept = (state == IDLE) && MStrobe && !strobe_q;
    assign finish = (state == BUSY) && (cnt == 8'd0);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE:    if (accept) state_nxt = BUSY;
            BUSY:    if (cnt == 8'd0) state_nxt = DONE;
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        MReady = 1'b0;
        MBusy  = 1'b0;
        unique case (state)
            IDLE: ;
            BUSY: MBusy = 1'b1;
            DONE: begin
                MReady = 1'b1;
                MBusy  = 1'b1;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            strobe_q <= 1'b0;
            cnt      <= 8'd0;
            rw_q     <= 1'b0;
            idx_q    <= '0;
            data_q   <= 32'd0;
            MDataR   <= 32'd0;
            RdCount  <= 16'd0;
            WrCount  <= 16'd0;
        end else begin
            strobe_q <= MStrobe;
            if (accept) begin
                cnt    <= LOAD;
                rw_q   <= MRW;
                idx_q  <= MAddress[ADDR_BITS+1:2];
                data_q <= MDataW;
            end else if (state == BUSY && cnt != 8'd0) begin
                cnt <= cnt - 8'd1;
            end
            if (finish) begin
                if (rw_q) begin
                    MDataR <= mem[idx_q];
                    if (RdCount != 16'hFFFF) RdCount <= RdCount + 16'd1;
                end else if (WrCount != 16'hFFFF) begin
                    WrCount <= WrCount + 16'd1;
                end
            end
        end
    end

    // Storage is deliberately outside the reset domain.
    always_ff @(posedge clk) begin
        if (finish && !rw_q) mem[idx_q] <= data_q;
    end

endmodule

// File: tb/tb_main_memory_controller.sv
// Randomised self-checking bench for main_memory_controller, comparing
// against a transaction-level memory model at latencies 4 and 1.
module tb_main_memory_controller;

    localparam int AB = 14;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        reset;
    logic        s4, rw4, rdy4, busy4;
    logic [31:0] a4, w4, r4;
    logic [15:0] rc4, wc4;
    logic        s1, rw1, rdy1, busy1;
    logic [31:0] a1, w1, r1;
    logic [15:0] rc1, wc1;

    int n_checks = 0;
    int n_fail   = 0;

    logic [31:0] mem4 [int];
    int mrd4 = 0, mwr4 = 0, mrd1 = 0, mwr1 = 0;
    logic [31:0] last_rd4;

    main_memory_controller #(.ADDR_BITS(AB), .LATENCY(4)) dut4 (
        .clk(clk), .reset(reset), .MStrobe(s4), .MRW(rw4),
        .MAddress(a4), .MDataW(w4), .MDataR(r4), .MReady(rdy4),
        .MBusy(busy4), .RdCount(rc4), .WrCount(wc4)
    );

    main_memory_controller #(.ADDR_BITS(AB), .LATENCY(1)) dut1 (
        .clk(clk), .reset(reset), .MStrobe(s1), .MRW(rw1),
        .MAddress(a1), .MDataW(w1), .MDataR(r1), .MReady(rdy1),
        .MBusy(busy1), .RdCount(rc1), .WrCount(wc1)
    );

    function automatic int widx(input logic [31:0] addr);
        return int'((addr >> 2) & ((32'd1 << AB) - 1));
    endfunction

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    // One transaction on the latency-4 instance; returns observed timing/data.
    task automatic run4(input logic rw, input logic [31:0] addr,
                        input logic [31:0] data, input logic [31:0] post_addr,
                        output int lat, output logic [31:0] rdata,
                        output logic ready_after, output logic busy_after);
        s4 = 1'b0;
        tick();
        s4 = 1'b1; rw4 = rw; a4 = addr; w4 = data;
        tick();
        s4 = 1'b0; a4 = post_addr; w4 = $urandom; rw4 = 1'($urandom);
        lat = 0;
        do begin
            tick();
            lat++;
        end while (!rdy4 && lat < 300);
        if (!rdy4) lat = -1;
        rdata = r4;
        tick();
        ready_after = rdy4;
        busy_after  = busy4;
        if (rw) begin
            if (mrd4 < 65535) mrd4++;
            last_rd4 = mem4[widx(addr)];
        end else begin
            mem4[widx(addr)] = data;
            if (mwr4 < 65535) mwr4++;
        end
    endtask

    task automatic test_reset;
        reset = 1'b0;
        s4 = 0; rw4 = 0; a4 = 0; w4 = 0;
        s1 = 0; rw1 = 0; a1 = 0; w1 = 0;
        tick(); tick();
        n_checks++;
        if ({rdy4, busy4, r4, rc4, wc4} !== 66'd0) begin
            n_fail++;
            $display("FAIL reset4: rdy=%b busy=%b rd=%h rc=%0d wc=%0d, want all 0",
                     rdy4, busy4, r4, rc4, wc4);
        end
        n_checks++;
        if ({rdy1, busy1, r1, rc1, wc1} !== 66'd0) begin
            n_fail++;
            $display("FAIL reset1: rdy=%b busy=%b rd=%h rc=%0d wc=%0d, want all 0",
                     rdy1, busy1, r1, rc1, wc1);
        end
        reset = 1'b1;
        tick();
        n_checks++;
        if (busy4 !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_release: busy=%b want 0", busy4);
        end
    endtask

    task automatic test_read_latency;
        int lat;
        logic [31:0] rd;
        logic ra, ba;
        run4(1'b0, 32'h0, 32'h23, 32'h0, lat, rd, ra, ba);
        run4(1'b0, 32'h4, 32'h07, 32'h4, lat, rd, ra, ba);
        run4(1'b1, 32'h0, 32'h0, 32'h0, lat, rd, ra, ba);
        n_checks++;
        if (lat !== 4) begin
            n_fail++;
            $display("FAIL read_latency: got %0d cycles want 4", lat);
        end
        n_checks++;
        if (rd !== 32'h23) begin
            n_fail++;
            $display("FAIL read_data: got %h want 00000023", rd);
        end
        n_checks++;
        if ({ra, ba} !== 2'b00) begin
            n_fail++;
            $display("FAIL ready_pulse: after-cycle ready=%b busy=%b want 0 0", ra, ba);
        end
        n_checks++;
        if (rc4 !== 16'(mrd4)) begin
            n_fail++;
            $display("FAIL rdcount: got %0d want %0d", rc4, mrd4);
        end
    endtask

    task automatic test_write_read;
        int lat;
        logic [31:0] rd, v1, v2;
        logic ra, ba;
        v1 = $urandom; v2 = $urandom;
        run4(1'b0, 32'hFFC, v1, 32'h0, lat, rd, ra, ba);
        run4(1'b0, 32'h1004, v2, 32'h0, lat, rd, ra, ba);
        run4(1'b0, 32'h1000, 32'h253, 32'h0, lat, rd, ra, ba);
        n_checks++;
        if (r4 !== last_rd4) begin
            n_fail++;
            $display("FAIL write_keeps_mdatar: got %h want %h", r4, last_rd4);
        end
        run4(1'b1, 32'h1000, 32'h0, 32'h0, lat, rd, ra, ba);
        n_checks++;
        if (rd !== 32'h253) begin
            n_fail++;
            $display("FAIL raw_same_idx: got %h want 00000253", rd);
        end
        run4(1'b1, 32'h0001_1003, 32'h0, 32'h0, lat, rd, ra, ba);
        n_checks++;
        if (rd !== 32'h253) begin
            n_fail++;
            $display("FAIL alias_read: got %h want 00000253", rd);
        end
        run4(1'b1, 32'hFFC, 32'h0, 32'h0, lat, rd, ra, ba);
        n_checks++;
        if (rd !== v1) begin
            n_fail++;
            $display("FAIL neighbour_below: got %h want %h", rd, v1);
        end
        run4(1'b1, 32'h1004, 32'h0, 32'h0, lat, rd, ra, ba);
        n_checks++;
        if (rd !== v2) begin
            n_fail++;
            $display("FAIL neighbour_above: got %h want %h", rd, v2);
        end
        n_checks++;
        if (wc4 !== 16'(mwr4)) begin
            n_fail++;
            $display("FAIL wrcount: got %0d want %0d", wc4, mwr4);
        end
    endtask

    task automatic test_held_strobe;
        int pulses = 0;
        s4 = 1'b0;
        tick();
        s4 = 1'b1; rw4 = 1'b1; a4 = 32'h0;
        for (int i = 0; i < 20; i++) begin
            tick();
            if (rdy4) pulses++;
        end
        s4 = 1'b0;
        tick(); tick();
        mrd4++;
        n_checks++;
        if (pulses !== 1) begin
            n_fail++;
            $display("FAIL held_strobe_pulses: got %0d want 1", pulses);
        end
        n_checks++;
        if (busy4 !== 1'b0) begin
            n_fail++;
            $display("FAIL held_strobe_busy: got %b want 0", busy4);
        end
        n_checks++;
        if (rc4 !== 16'(mrd4) || r4 !== mem4[0]) begin
            n_fail++;
            $display("FAIL held_strobe_read: rc=%0d rd=%h want %0d %h",
                     rc4, r4, mrd4, mem4[0]);
        end
    endtask

    task automatic test_strobe_drop;
        int lat;
        logic [31:0] rd, old2, v;
        logic ra, ba;
        old2 = 32'h1234_0000 ^ ($urandom & 32'hFFFF);
        v = $urandom;
        run4(1'b0, 32'h8, old2, 32'h0, lat, rd, ra, ba);
        run4(1'b0, 32'h4, v, 32'h8, lat, rd, ra, ba);
        run4(1'b1, 32'h4, 32'h0, 32'h0, lat, rd, ra, ba);
        n_checks++;
        if (rd !== v) begin
            n_fail++;
            $display("FAIL drop_idx1: got %h want %h", rd, v);
        end
        run4(1'b1, 32'h8, 32'h0, 32'h0, lat, rd, ra, ba);
        n_checks++;
        if (rd !== old2) begin
            n_fail++;
            $display("FAIL drop_idx2: got %h want %h", rd, old2);
        end
    endtask

    task automatic test_reset_abort;
        int lat, pulses = 0;
        logic [31:0] rd;
        logic ra, ba;
        s4 = 1'b0;
        tick();
        s4 = 1'b1; rw4 = 1'b0; a4 = 32'h8; w4 = 32'hDEAD;
        tick();
        s4 = 1'b0;
        tick(); tick();
        reset = 1'b0;
        #1;
        n_checks++;
        if ({busy4, rc4, wc4} !== 33'd0) begin
            n_fail++;
            $display("FAIL abort_state: busy=%b rc=%0d wc=%0d want 0 0 0",
                     busy4, rc4, wc4);
        end
        for (int i = 0; i < 4; i++) begin
            tick();
            if (rdy4) pulses++;
        end
        reset = 1'b1;
        mrd4 = 0; mwr4 = 0; mrd1 = 0; mwr1 = 0;
        for (int i = 0; i < 4; i++) begin
            tick();
            if (rdy4) pulses++;
        end
        n_checks++;
        if (pulses !== 0) begin
            n_fail++;
            $display("FAIL abort_ready: got %0d pulses want 0", pulses);
        end
        run4(1'b1, 32'h8, 32'h0, 32'h0, lat, rd, ra, ba);
        n_checks++;
        if (rd !== mem4[2]) begin
            n_fail++;
            $display("FAIL abort_no_commit: got %h want %h", rd, mem4[2]);
        end
        n_checks++;
        if (rc4 !== 16'(mrd4) || wc4 !== 16'(mwr4)) begin
            n_fail++;
            $display("FAIL abort_counts: rc=%0d wc=%0d want %0d %0d",
                     rc4, wc4, mrd4, mwr4);
        end
    endtask

    task automatic test_random;
        int lat, idx;
        logic [31:0] rd, addr, exp;
        logic ra, ba, rw;
        for (int i = 0; i < 8; i++)
            run4(1'b0, 32'(i * 4), $urandom, 32'h0, lat, rd, ra, ba);
        for (int i = 0; i < 30; i++) begin
            idx  = $urandom_range(0, 7);
            addr = ($urandom << 16) | 32'(idx << 2) | 32'($urandom_range(0, 3));
            rw   = 1'($urandom);
            exp  = mem4[idx];
            run4(rw, addr, $urandom, $urandom, lat, rd, ra, ba);
            n_checks++;
            if (lat !== 4 || ra !== 1'b0 || ba !== 1'b0) begin
                n_fail++;
                $display("FAIL rand_timing[%0d]: lat=%0d ra=%b ba=%b want 4 0 0",
                         i, lat, ra, ba);
            end
            if (rw) begin
                n_checks++;
                if (rd !== exp) begin
                    n_fail++;
                    $display("FAIL rand_read[%0d]: addr=%h got %h want %h",
                             i, addr, rd, exp);
                end
            end
        end
        n_checks++;
        if (rc4 !== 16'(mrd4) || wc4 !== 16'(mwr4)) begin
            n_fail++;
            $display("FAIL rand_counts: rc=%0d wc=%0d want %0d %0d",
                     rc4, wc4, mrd4, mwr4);
        end
    endtask

    task automatic test_lat1_back_to_back;
        logic [31:0] v;
        logic exp_rdy [14];
        logic got_rdy [14];
        logic [31:0] got_rd [14];
        int done_edge = -10;
        v = $urandom;
        s1 = 1'b0;
        tick();
        s1 = 1'b1; rw1 = 1'b0; a1 = 32'h40; w1 = v;
        tick();
        s1 = 1'b0;
        tick(); tick();
        mwr1++;
        // Rises at even edges; a rise is taken only once the previous
        // transaction has left DONE, i.e. strictly after done_edge + 1.
        for (int c = 0; c < 14; c++) exp_rdy[c] = 1'b0;
        for (int e = 0; e < 12; e += 2) begin
            if (e > done_edge + 1) begin
                done_edge = e + 1;
                exp_rdy[done_edge] = 1'b1;
                mrd1++;
            end
        end
        for (int c = 0; c < 14; c++) begin
            s1  = (c < 12) && (c % 2 == 0);
            rw1 = 1'b1;
            a1  = 32'h40;
            tick();
            got_rdy[c] = rdy1;
            got_rd[c]  = r1;
        end
        for (int c = 0; c < 14; c++) begin
            n_checks++;
            if (got_rdy[c] !== exp_rdy[c]) begin
                n_fail++;
                $display("FAIL lat1_ready[%0d]: got %b want %b",
                         c, got_rdy[c], exp_rdy[c]);
            end
            if (exp_rdy[c]) begin
                n_checks++;
                if (got_rd[c] !== v) begin
                    n_fail++;
                    $display("FAIL lat1_data[%0d]: got %h want %h", c, got_rd[c], v);
                end
            end
        end
        n_checks++;
        if (rc1 !== 16'(mrd1) || wc1 !== 16'(mwr1)) begin
            n_fail++;
            $display("FAIL lat1_counts: rc=%0d wc=%0d want %0d %0d",
                     rc1, wc1, mrd1, mwr1);
        end
    endtask

    initial begin
        last_rd4 = 32'h0;
        test_reset();
        test_read_latency();
        test_write_read();
        test_held_strobe();
        test_strobe_drop();
        test_reset_abort();
        test_random();
        test_lat1_back_to_back();
        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_checks, n_fail);
        $finish;
    end

endmodule
